// File: rtl/cpu_step_ctrl_pkg.sv
// Shared state encodings and parameter defaults for the CPU step controller.
`timescale 1ns/1ps
package cpu_step_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_STEP_IDLE = 2'd1,
        MODE_STEP_FIRE = 2'd2
    } mode_t;

    localparam int DB_MAX_DEFAULT = 1000000;
    localparam int DB_W_DEFAULT   = 20;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Push-button synchroniser and debouncer; emits a one-cycle press pulse when
// the debounced level rises.
`timescale 1ns/1ps
module cpu_step_ctrl_btn_debounce
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DB_MAX = DB_MAX_DEFAULT,
    parameter int DB_W   = DB_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic            s1_reg, s2_reg;
    logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
    logic            db_lvl_reg, db_lvl_next;
    logic            press_reg, press_next;

    always_comb begin
        db_cnt_next = db_cnt_reg + DB_W'(1);
        db_lvl_next = db_lvl_reg;
        press_next  = 1'b0;
        if (s2_reg == db_lvl_reg) begin
            db_cnt_next = '0;
        end else if (db_cnt_reg == DB_W'(DB_MAX - 1)) begin
            // Input has disagreed for DB_MAX consecutive cycles: accept it.
            db_cnt_next = '0;
            db_lvl_next = s2_reg;
            press_next  = s2_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg     <= 1'b0;
            s2_reg     <= 1'b0;
            db_cnt_reg <= '0;
            db_lvl_reg <= 1'b0;
            press_reg  <= 1'b0;
        end else begin
            s1_reg     <= btn;
            s2_reg     <= s1_reg;
            db_cnt_reg <= db_cnt_next;
            db_lvl_reg <= db_lvl_next;
            press_reg  <= press_next;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns a divided clock tap into single-cycle CPU enable strobes, with a
// debounced single-step mode driven by a push-button.
`timescale 1ns/1ps
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DB_MAX = DB_MAX_DEFAULT,
    parameter int DB_W   = DB_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        slow_clk,
    input  logic        step_mode,
    input  logic        step_btn,
    output logic        cpu_en,
    output logic [31:0] step_cnt,
    output logic [1:0]  mode
);

    logic [1:0] async_in;
    logic [1:0] sync_out;
    logic       slow_p_reg;
    logic       tick;
    logic       msm;
    logic       press;

    mode_t       state_reg, state_next;
    logic        cpu_en_reg, cpu_en_next;
    logic [31:0] step_cnt_reg;

    // Bit 0 carries the clock tap, bit 1 the mode switch.
    assign async_in = {step_mode, slow_clk};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic s1_reg, s2_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_reg <= 1'b0;
                s2_reg <= 1'b0;
            end else begin
                s1_reg <= async_in[gi];
                s2_reg <= s1_reg;
            end
        end
        assign sync_out[gi] = s2_reg;
    end

    assign tick = sync_out[0] & ~slow_p_reg;
    assign msm  = sync_out[1];

    cpu_step_ctrl_btn_debounce #(
        .DB_MAX (DB_MAX),
        .DB_W   (DB_W)
    ) u_btn_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (step_btn),
        .press (press)
    );

    always_comb begin
        state_next  = state_reg;
        cpu_en_next = 1'b0;
        unique case (state_reg)
            MODE_RUN: begin
                // A tick coincident with entering step mode is still honoured.
                cpu_en_next = tick;
                state_next  = msm ? MODE_STEP_IDLE : MODE_RUN;
            end
            MODE_STEP_IDLE: begin
                if (!msm) begin
                    state_next = MODE_RUN;
                end else if (press) begin
                    state_next  = MODE_STEP_FIRE;
                    cpu_en_next = 1'b1;
                end
            end
            MODE_STEP_FIRE: begin
                state_next = msm ? MODE_STEP_IDLE : MODE_RUN;
            end
            default: begin
                state_next = MODE_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slow_p_reg   <= 1'b0;
            state_reg    <= MODE_RUN;
            cpu_en_reg   <= 1'b0;
            step_cnt_reg <= '0;
        end else begin
            slow_p_reg <= sync_out[0];
            state_reg  <= state_next;
            cpu_en_reg <= cpu_en_next;
            if (cpu_en_reg) begin
                step_cnt_reg <= step_cnt_reg + 32'd1;
            end
        end
    end

    assign cpu_en   = cpu_en_reg;
    assign step_cnt = step_cnt_reg;
    assign mode     = state_reg;

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Consumes a divided clock tap (e.g. clkdiv bit 22 or bit 4) in the fast system clock domain.
- Converts each tap rising edge into a single-cycle CPU clock-enable strobe, so downstream logic runs on clk with no derived clocks.
- Adds a single-step mode: each debounced press of a push-button produces exactly one strobe.
- Sits between the clock divider and the CPU/game core.

Parameters:
- DB_MAX, 1000000, debounce stability count in clk cycles (10 ms at 100 MHz). Must be >= 2.
- DB_W, 20, debounce counter width. Must satisfy 2^DB_W > DB_MAX.

Ports:
- clk  in  1  system clock, all flops on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- slow_clk  in  1  divided clock tap; asynchronous to clk for timing purposes.
- step_mode  in  1  switch input: 1 = single-step, 0 = free-run.
- step_btn  in  1  raw push-button input, active high, bouncy.
- cpu_en  out  1  registered one-cycle enable strobe.
- step_cnt  out  32  number of cpu_en strobes issued since reset.
- mode  out  2  FSM state: 0 = RUN, 1 = STEP_IDLE, 2 = STEP_FIRE.

Behaviour:
- Reset: one clock (clk). Reset is asynchronous and active-low (rst_n). While rst_n = 0:
  - all flops are 0, the FSM is in RUN, the debounced button level is 0;
  - outputs are cpu_en = 0, step_cnt = 0, mode = 0.
- Synchronisers: slow_clk, step_mode and step_btn each pass through two flops (s1, s2).
  - slow_clk also has a delay flop p.
  - tick = s2 & ~p (combinational, internal).
- Strobe latency: if slow_clk rises and meets setup before clk edge E0, then:
  - s2 is high after E1 and tick is high during the E1–E2 cycle;
  - cpu_en is high from E2 to E3, exactly one cycle.
- Edge counting: one cpu_en per slow_clk rising edge in RUN. No strobe on falling edges.
- slow_clk high at reset release is treated as a rising edge: one strobe, at the 3rd edge after release.
- Debouncer:
  - Counter db_cnt (DB_W bits) and stable level db_lvl.
  - If the synced button equals db_lvl, db_cnt clears to 0.
  - Otherwise db_cnt increments. When db_cnt == DB_MAX-1, db_lvl takes the synced value and db_cnt clears.
  - press = one-cycle pulse on a db_lvl 0->1 transition. Release is filtered identically and produces no pulse.
  - A glitch shorter than DB_MAX cycles never changes db_lvl.
- FSM (msm = synced step_mode). Each row: state, condition, next state, cpu_en on the next edge.
  - RUN: msm = 1 -> STEP_IDLE, cpu_en = tick. A tick coincident with the mode change is still issued.
  - RUN: msm = 0 -> RUN, cpu_en = tick.
  - STEP_IDLE: msm = 0 -> RUN, cpu_en = 0. The press is ignored, and the tick is ignored.
  - STEP_IDLE: msm = 1 and press -> STEP_FIRE, cpu_en = 1.
  - STEP_IDLE: otherwise -> stay, cpu_en = 0. Ticks are ignored.
  - STEP_FIRE: msm = 1 -> STEP_IDLE, cpu_en = 0.
  - STEP_FIRE: msm = 0 -> RUN, cpu_en = 0.
  - Result: the step strobe is high during the cycle the FSM is in STEP_FIRE.
- cpu_en is never high on two consecutive cycles in STEP mode.
- In RUN, consecutive strobes are separated by at least one low cycle, because a tick needs a new 0->1 on s2.
- The debouncer keeps running in all states. A press pending in RUN does not carry over into STEP_IDLE, because press is a pulse only.
- step_cnt:
  - increments by 1 on every clk edge where cpu_en is 1;
  - is 32-bit modulo, wrapping 0xFFFFFFFF -> 0x00000000 with no flag.
- Reset mid-operation: asynchronous clear of everything. A strobe in flight is dropped. A step_mode switch already high returns the block to STEP_IDLE 3 cycles after release (2 sync + 1 FSM).

Decomposition:
- Shared package holds:
  - state encodings MODE_RUN = 2'd0, MODE_STEP_IDLE = 2'd1, MODE_STEP_FIRE = 2'd2;
  - the default DB_MAX.
- One natural sub-module: btn_debounce (2-flop sync, db_cnt, db_lvl, press pulse), parameterised by DB_MAX/DB_W.
- The synchronisers, edge detect and FSM stay in cpu_step_ctrl.

Test Plan:
- Reset with DB_MAX = 4, step_mode = 0, slow_clk = 0.
  - Stimulus: square wave with period 16 clk for 5 periods.
  - Response: exactly 5 one-cycle cpu_en pulses; each asserts at the 3rd clk edge after the slow_clk rise; step_cnt = 5; mode = 0 throughout.
- step_mode = 1 with slow_clk toggling.
  - Stimulus: hold step_btn high for 10 cycles, twice, separated by 10 low cycles.
  - Response: no tick strobes; exactly 2 cpu_en pulses; step_cnt = 2; mode visits 1 -> 2 -> 1.
- Bounce rejection in STEP mode.
  - Stimulus: step_btn pulses of 1, 2 and 3 cycles, then stable high for 8 cycles.
  - Response: exactly 1 cpu_en, issued DB_MAX + 3 cycles after stable high begins.
- Mode switching.
  - Stimulus: step_mode 0 -> 1 timed so the tick lands on the same cycle.
  - Response: that tick's strobe is issued, later ticks are suppressed, and the mode returns to 0 within 3 cycles after step_mode drops.
- Wrap-around.
  - Stimulus: force step_cnt = 0xFFFFFFFE (hierarchical deposit), then issue 2 strobes.
  - Response: step_cnt reads 0xFFFFFFFF, then 0x00000000.
- Reset mid-operation.
  - Stimulus: assert rst_n = 0 asynchronously on the cycle before a strobe; slow_clk high at release.
  - Response: cpu_en = 0, step_cnt = 0 and mode = 0 immediately; one cpu_en at the 3rd edge after release.
